// File: rtl/rf_operand_fetch.sv
// rf_operand_fetch
//   ID-stage operand fetch. Drives the register-file read addresses, picks
//   each source operand from the RF or the EX/MEM/WB result buses, tracks
//   in-flight writes per register with a small scoreboard, stalls on
//   load-use and on hazards that cannot be forwarded, and registers the
//   resolved operands into an ID/EX stage with a valid/ready handshake.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      decoded instruction handshake from IF/ID
//   in_rs, in_rt             source registers; in_use_rs/in_use_rt: actually read
//   in_rd, in_wr, in_load    destination, writes-rd flag, load flag
//   rf_rs_addr, rf_rt_addr   RF read addresses (= in_rs / in_rt)
//   rf_rs_data, rf_rt_data   RF read data (combinational)
//   ex_wr/ex_load/ex_rd/ex_data   EX stage result bus
//   mem_wr/mem_rd/mem_data        MEM stage result bus
//   wb_wr/wb_rd/wb_data           WB bus (also the RF write port)
//   out_valid / out_ready    ID/EX handshake towards EX
//   out_rs_val, out_rt_val   resolved operands
//   out_rd, out_wr, out_load passed-through control
//
// Configuration macro
//   WB_FWD_EN  when defined, a WB match forwards wb_data explicitly (needed if
//              the RF write moves to posedge). Otherwise a WB match reads the
//              RF, which was already written on the preceding negedge.

module rf_operand_fetch #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs,
    input  logic [ADDR_W-1:0] in_rt,
    input  logic              in_use_rs,
    input  logic              in_use_rt,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_wr,
    input  logic              in_load,
    output logic [ADDR_W-1:0] rf_rs_addr,
    output logic [ADDR_W-1:0] rf_rt_addr,
    input  logic [DATA_W-1:0] rf_rs_data,
    input  logic [DATA_W-1:0] rf_rt_data,
    input  logic              ex_wr,
    input  logic              ex_load,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_wr,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rs_val,
    output logic [DATA_W-1:0] out_rt_val,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_wr,
    output logic              out_load
);

    localparam int NREG = 2 ** ADDR_W;

    logic [CNT_W-1:0]  count [NREG];
    logic [NREG-1:0]   inc_vec;
    logic [NREG-1:0]   dec_vec;

    logic rs_ex, rs_mem, rs_wb;
    logic rt_ex, rt_mem, rt_wb;
    logic rs_hazard, rt_hazard, saturation;
    logic accept;
    logic [DATA_W-1:0] rs_val, rt_val;

    // A bus hit only counts for a nonzero register with its write flag set.
    function automatic logic bus_hit(input logic wr, input logic [ADDR_W-1:0] rd,
                                     input logic [ADDR_W-1:0] src);
        return wr && (rd == src) && (src != '0);
    endfunction

    assign rf_rs_addr = in_rs;
    assign rf_rt_addr = in_rt;

`ifndef WB_FWD_EN
    // wb_data only feeds the RF in this build; keep it visibly consumed.
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data;
`endif

    always_comb begin
        rs_ex  = bus_hit(ex_wr,  ex_rd,  in_rs);
        rs_mem = bus_hit(mem_wr, mem_rd, in_rs);
        rs_wb  = bus_hit(wb_wr,  wb_rd,  in_rs);
        rt_ex  = bus_hit(ex_wr,  ex_rd,  in_rt);
        rt_mem = bus_hit(mem_wr, mem_rd, in_rt);
        rt_wb  = bus_hit(wb_wr,  wb_rd,  in_rt);

        // Priority EX > MEM > WB > RF; register 0 is hard-wired to zero.
        rs_val = rf_rs_data;
        if (in_rs == '0)  rs_val = '0;
        else if (rs_ex)   rs_val = ex_data;
        else if (rs_mem)  rs_val = mem_data;
`ifdef WB_FWD_EN
        else if (rs_wb)   rs_val = wb_data;
`endif

        rt_val = rf_rt_data;
        if (in_rt == '0)  rt_val = '0;
        else if (rt_ex)   rt_val = ex_data;
        else if (rt_mem)  rt_val = mem_data;
`ifdef WB_FWD_EN
        else if (rt_wb)   rt_val = wb_data;
`endif

        // A pending count with no bus carrying the producer means the value
        // is somewhere the buses cannot see yet.
        rs_hazard = in_use_rs && (in_rs != '0) &&
                    ((out_valid && out_wr && (out_rd == in_rs)) ||
                     (rs_ex && ex_load) ||
                     ((count[in_rs] != '0) && !rs_ex && !rs_mem && !rs_wb));
        rt_hazard = in_use_rt && (in_rt != '0) &&
                    ((out_valid && out_wr && (out_rd == in_rt)) ||
                     (rt_ex && ex_load) ||
                     ((count[in_rt] != '0) && !rt_ex && !rt_mem && !rt_wb));

        saturation = in_wr && (in_rd != '0) && (count[in_rd] == '1);

        in_ready = (!out_valid || out_ready) && !rs_hazard && !rt_hazard && !saturation;
        accept   = in_valid && in_ready;

        inc_vec = '0;
        dec_vec = '0;
        if (accept && in_wr) inc_vec[in_rd] = 1'b1;
        if (wb_wr)           dec_vec[wb_rd] = 1'b1;
        inc_vec[0] = 1'b0;
        dec_vec[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_rs_val <= '0;
            out_rt_val <= '0;
            out_rd     <= '0;
            out_wr     <= 1'b0;
            out_load   <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_rs_val <= rs_val;
            out_rt_val <= rt_val;
            out_rd     <= in_rd;
            out_wr     <= in_wr;
            out_load   <= in_load;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Simultaneous issue and retire on one register cancel out; a retire of
    // a write issued before reset finds the counter at 0 and is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) count[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (inc_vec[i] && !dec_vec[i])
                    count[i] <= count[i] + CNT_W'(1);
                else if (dec_vec[i] && !inc_vec[i] && (count[i] != '0))
                    count[i] <= count[i] - CNT_W'(1);
            end
        end
    end

endmodule
